// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

    // Width of the Avalon write data bus.
    localparam int DATA_W = 32;

    // Animation selected by the mode input.
    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;

    // Avalon write FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    // Bounce direction.
    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-rate prescaler: produces one tick every max(period,1) enabled cycles.
module led_seq_prescaler #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] limit;

    // A period of 0 behaves as 1. The >= compare makes a shrunk period fire
    // at once instead of waiting for the counter to wrap around.
    assign limit  = (period_i == '0) ? '0 : period_i - DIV_W'(1);
    assign tick_o = enable_i & (cnt_q >= limit);

    // Next count: cleared while disabled, on reload and on every tick.
    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clear_i || !enable_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: steps an animation at the prescaler rate and pushes
// every new pattern to the PIO data register with a single Avalon-MM write.
//
// Handshake: a write is offered while m_chipselect=1 and m_write_n=0 (the
// valid side); address and data stay frozen until a cycle with
// m_waitrequest=0 (the ready side), which is the cycle the slave accepts it.
// Reset deassertion is expected to be synchronous to clk upstream.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int         LED_W    = 8,
    parameter int         DIV_W    = 32,
    parameter logic [1:0] PIO_ADDR = 2'd0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  period,
    input  logic [LED_W-1:0]  pattern_init,
    input  logic              load,
    output logic [1:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [DATA_W-1:0] m_writedata,
    input  logic              m_waitrequest,
    output logic              busy,
    output logic              overrun,
    output logic [LED_W-1:0]  pattern,
    output state_e            dbg_state
);

    state_e            state_q, state_d;
    logic [LED_W-1:0]  pattern_q, pattern_d;
    logic [LED_W-1:0]  wdata_q, wdata_d;
    logic              dir_q, dir_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              tick;
    logic              step;
    logic [LED_W-1:0]  nxt_pat;
    logic              nxt_dir;

    led_seq_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable_i (enable),
        .clear_i  (load),
        .period_i (period),
        .tick_o   (tick)
    );

    // Load wins over a coincident tick.
    assign step = tick & ~load;

    // Next pattern and bounce direction for one animation step.
    always_comb begin
        nxt_pat = pattern_q;
        nxt_dir = dir_q;
        case (mode_e'(mode))
            MODE_STATIC: nxt_pat = pattern_init;
            MODE_ROTATE: nxt_pat = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
            MODE_BOUNCE: begin
                if (dir_q == DIR_L) begin
                    if (pattern_q[LED_W-1]) begin
                        nxt_pat = pattern_q >> 1;
                        nxt_dir = DIR_R;
                    end else begin
                        nxt_pat = pattern_q << 1;
                    end
                end else begin
                    if (pattern_q[0]) begin
                        nxt_pat = pattern_q << 1;
                        nxt_dir = DIR_L;
                    end else begin
                        nxt_pat = pattern_q >> 1;
                    end
                end
            end
            MODE_COUNT:  nxt_pat = pattern_q + LED_W'(1);
            default:     nxt_pat = pattern_q;
        endcase
    end

    // Pattern update, write FSM, pending/overrun bookkeeping.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        wdata_d   = wdata_q;
        dir_d     = dir_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        if (load) begin
            pattern_d = pattern_init;
            dir_d     = DIR_L;
        end else if (step) begin
            pattern_d = nxt_pat;
            dir_d     = nxt_dir;
        end

        case (state_q)
            ST_IDLE: begin
                // Latch the freshest pattern, including a same-cycle step.
                if (load || step || pending_q) begin
                    wdata_d   = pattern_d;
                    pending_d = 1'b0;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Bus data is frozen; new values queue as a single pending write.
                if (load || step) begin
                    if (step && pending_q) begin
                        overrun_d = 1'b1;
                    end
                    pending_d = 1'b1;
                end
                if (!m_waitrequest) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            overrun_d = 1'b0;
        end
    end

    // State registers; reset drops chipselect immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            wdata_q   <= '0;
            dir_q     <= DIR_L;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            wdata_q   <= wdata_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign m_address    = PIO_ADDR;
    assign m_chipselect = (state_q == ST_WRITE);
    assign m_write_n    = ~m_chipselect;
    assign m_writedata  = DATA_W'(wdata_q);
    assign busy         = m_chipselect;
    assign overrun      = overrun_q;
    assign pattern      = pattern_q;
    assign dbg_state    = state_q;

endmodule
